ospi_target_mem: RTL and testbench



---
 rtl/ospi_target_mem.sv | 182 ++++++++++++++++++
 tb/tb_ospi_target_mem.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ospi_target_mem.sv
// rtl/ospi_target_mem.sv - parametrised octal/hex-SPI target with burst RAM, ID and status reads
module ospi_target_mem #(
    parameter int         DATA_W    = 8,
    parameter int         ADDR_W    = 24,
    parameter int         MEM_AW    = 18,
    parameter int         DUMMY_CYC = 2,
    parameter logic [7:0] ID_VALUE  = 8'h5A
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ncs,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_oe,
    output logic              dqs_o,
    output logic              dqs_oe,
    output logic              txn_done,
    output logic              txn_err
);
    localparam int ADDR_BEATS = (ADDR_W + DATA_W - 1) / DATA_W;

    typedef enum logic [2:0] {IDLE, HDR, DUMMY, DATA, DONE} state_t;
    typedef enum logic [2:0] {K_BAD, K_WR, K_RD, K_ID, K_ST} kind_t;

    state_t state, state_n;
    kind_t  kind, kind_n;
    logic [7:0]        cnt, cnt_n, len, len_n;
    logic [MEM_AW-1:0] ptr, ptr_n;
    logic [DATA_W-1:0] mem [2**MEM_AW];
    logic [DATA_W-1:0] rd_word;
    logic data_oe_n, dqs_oe_n, dqs_n, load_n, done_n, err_n, wr_en;
    logic set_wr, set_err, clr_sticky, read_kind;
    logic wr_sticky, err_sticky;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n    = state;
        kind_n     = kind;
        cnt_n      = cnt;
        len_n      = len;
        ptr_n      = ptr;
        data_oe_n  = 1'b0;
        dqs_oe_n   = 1'b0;
        dqs_n      = 1'b0;
        load_n     = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        wr_en      = 1'b0;
        set_wr     = 1'b0;
        set_err    = 1'b0;
        clr_sticky = 1'b0;
        read_kind  = (kind == K_RD) || (kind == K_ID) || (kind == K_ST);
        unique case (kind)
            K_ID:    rd_word = DATA_W'(ID_VALUE);
            K_ST:    rd_word = DATA_W'({err_sticky, wr_sticky});
            default: rd_word = mem[ptr];
        endcase
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                len_n = '0;
                if (!ncs) begin
                    unique case (data_i[7:0])
                        8'hA0: begin kind_n = K_WR; state_n = HDR; end
                        8'h20: begin kind_n = K_RD; state_n = HDR; end
                        8'h9F: begin kind_n = K_ID; state_n = DUMMY; dqs_oe_n = 1'b1; end
                        8'h05: begin kind_n = K_ST; state_n = DUMMY; dqs_oe_n = 1'b1; end
                        default: begin kind_n = K_BAD; state_n = DONE; err_n = 1'b1; end
                    endcase
                end
            end
            HDR: begin
                cnt_n = cnt + 8'd1;
                // Address arrives MSB first; only the low MEM_AW bits survive the shift.
                if (cnt == 8'd0) len_n = data_i[7:0];
                else             ptr_n = (ptr << DATA_W) | MEM_AW'(data_i);
                if (cnt == 8'(ADDR_BEATS)) begin
                    cnt_n = '0;
                    if (kind == K_WR) begin
                        state_n = DATA;
                    end else begin
                        state_n  = DUMMY;
                        dqs_oe_n = 1'b1;
                    end
                end
            end
            DUMMY: begin
                dqs_oe_n = 1'b1;
                cnt_n    = cnt + 8'd1;
                if (cnt == 8'(DUMMY_CYC - 1)) begin
                    cnt_n      = '0;
                    state_n    = DATA;
                    data_oe_n  = 1'b1;
                    dqs_n      = 1'b1;
                    load_n     = 1'b1;
                    ptr_n      = ptr + 1'b1;
                    clr_sticky = (kind == K_ST);
                end
            end
            DATA: begin
                if (kind == K_WR) begin
                    wr_en = 1'b1;
                    ptr_n = ptr + 1'b1;
                end
                if (cnt == len) begin
                    state_n  = DONE;
                    done_n   = 1'b1;
                    set_wr   = (kind == K_WR);
                    dqs_oe_n = read_kind;
                end else begin
                    cnt_n = cnt + 8'd1;
                    if (kind != K_WR) begin
                        // Output register holds the next beat, so its strobe phase is cnt+1.
                        data_oe_n = 1'b1;
                        dqs_oe_n  = 1'b1;
                        dqs_n     = cnt[0];
                        load_n    = 1'b1;
                        ptr_n     = ptr + 1'b1;
                    end
                end
            end
            DONE: dqs_oe_n = read_kind;
            default: state_n = IDLE;
        endcase
        if (ncs) begin
            state_n    = IDLE;
            data_oe_n  = 1'b0;
            dqs_oe_n   = 1'b0;
            dqs_n      = 1'b0;
            load_n     = 1'b0;
            done_n     = 1'b0;
            wr_en      = 1'b0;
            set_wr     = 1'b0;
            clr_sticky = 1'b0;
            err_n      = state inside {HDR, DUMMY, DATA};
            set_err    = err_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            kind       <= K_BAD;
            cnt        <= '0;
            len        <= '0;
            ptr        <= '0;
            data_o     <= '0;
            data_oe    <= 1'b0;
            dqs_o      <= 1'b0;
            dqs_oe     <= 1'b0;
            txn_done   <= 1'b0;
            txn_err    <= 1'b0;
            wr_sticky  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            kind     <= kind_n;
            cnt      <= cnt_n;
            len      <= len_n;
            ptr      <= ptr_n;
            data_o   <= load_n ? rd_word : '0;
            data_oe  <= data_oe_n;
            dqs_o    <= dqs_n;
            dqs_oe   <= dqs_oe_n;
            txn_done <= done_n;
            txn_err  <= err_n;
            if (clr_sticky) begin
                wr_sticky  <= 1'b0;
                err_sticky <= 1'b0;
            end
            if (set_wr)  wr_sticky  <= 1'b1;
            if (set_err) err_sticky <= 1'b1;
        end
    end

    // Reset also blocks the write so an interrupted beat never lands in RAM.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) mem[ptr] <= data_i;
    end
endmodule

// File: tb/tb_ospi_target_mem.sv
// tb/tb_ospi_target_mem.sv - directed scoreboard bench for ospi_target_mem (8-bit and 16-bit/4-bit-deep instances)
module tb_ospi_target_mem;
    localparam int DUMMY = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ncs = 1'b1;
    logic        sel = 1'b0;
    logic [15:0] din = '0;

    logic [7:0]  d8_o;
    logic        d8_oe, q8_o, q8_oe, done8, err8;
    logic [15:0] d16_o;
    logic        d16_oe, q16_o, q16_oe, done16, err16;
    logic        ncs8, ncs16;
    logic [15:0] dout;
    logic        doe, qo, qoe, tdone, terr;

    int checks = 0, passed = 0, fails = 0, done_cnt = 0, err_cnt = 0;
    logic [16:0] exp_q[$];
    logic [15:0] mdl[int];

    always #5 clk = ~clk;

    assign ncs8  = sel ? 1'b1 : ncs;
    assign ncs16 = sel ? ncs : 1'b1;
    assign dout  = sel ? d16_o : {8'h00, d8_o};
    assign doe   = sel ? d16_oe : d8_oe;
    assign qo    = sel ? q16_o : q8_o;
    assign qoe   = sel ? q16_oe : q8_oe;
    assign tdone = sel ? done16 : done8;
    assign terr  = sel ? err16 : err8;

    ospi_target_mem #(.DATA_W(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .ncs(ncs8), .data_i(din[7:0]),
        .data_o(d8_o), .data_oe(d8_oe), .dqs_o(q8_o), .dqs_oe(q8_oe),
        .txn_done(done8), .txn_err(err8)
    );

    ospi_target_mem #(.DATA_W(16), .MEM_AW(4)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .ncs(ncs16), .data_i(din),
        .data_o(d16_o), .data_oe(d16_oe), .dqs_o(q16_o), .dqs_oe(q16_oe),
        .txn_done(done16), .txn_err(err16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tdone) done_cnt++;
        if (terr) err_cnt++;
        if (doe) begin
            if (exp_q.size() == 0) check("bus_driven_unexpectedly", 32'(doe), 32'h0);
            else check("read_beat", 32'({qo, dout}), 32'(exp_q.pop_front()));
        end
    end

    function automatic int key(input int a);
        return sel ? (32'h100000 | (a & 15)) : (a & 32'h3FFFF);
    endfunction

    task automatic cyc(input logic n, input logic [15:0] d);
        ncs = n;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic header(input logic [7:0] cmd, input logic [7:0] len, input logic [31:0] a);
        cyc(1'b0, {8'h00, cmd});
        cyc(1'b0, {8'h00, len});
        if (sel) begin
            cyc(1'b0, a[31:16]);
            cyc(1'b0, a[15:0]);
        end else begin
            cyc(1'b0, {8'h00, a[23:16]});
            cyc(1'b0, {8'h00, a[15:8]});
            cyc(1'b0, {8'h00, a[7:0]});
        end
    endtask

    // Entered on the first DUMMY cycle; walks dummy, data and DONE, then deselects.
    task automatic read_out(input string tag, input int nbeats);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < DUMMY; i++) begin
            check({tag, "_dummy"}, 32'({doe, qoe, qo}), 32'h2);
            cyc(1'b0, 16'h0);
        end
        for (int k = 0; k < nbeats; k++) begin
            check({tag, "_data_oe"}, 32'(doe), 32'h1);
            cyc(1'b0, 16'h0);
        end
        check({tag, "_done_hold"}, 32'({tdone, doe, qoe}), 32'h5);
        cyc(1'b1, 16'h0);
        check({tag, "_released"}, 32'({doe, qoe, tdone, terr}), 32'h0);
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'h1);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic read_txn(input string tag, input logic [31:0] a, input int len);
        header(8'h20, 8'(len), a);
        for (int k = 0; k <= len; k++)
            exp_q.push_back({(k % 2 == 0), mdl[key(int'(a) + k)]});
        read_out(tag, len + 1);
    endtask

    task automatic write_txn(input string tag, input logic [31:0] a, input logic [63:0] words, input int n);
        int d0;
        d0 = done_cnt;
        header(8'hA0, 8'(n - 1), a);
        for (int k = 0; k < n; k++) begin
            check({tag, "_bus_idle"}, 32'({doe, qoe}), 32'h0);
            cyc(1'b0, words[16*k +: 16]);
            mdl[key(int'(a) + k)] = words[16*k +: 16];
        end
        check({tag, "_done"}, 32'({tdone, doe, qoe}), 32'h4);
        cyc(1'b1, 16'h0);
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'h1);
    endtask

    task automatic short_cmd(input string tag, input logic [7:0] cmd, input logic [15:0] exp);
        cyc(1'b0, {8'h00, cmd});
        exp_q.push_back({1'b1, exp});
        read_out(tag, 1);
    endtask

    initial begin
        int e0;
        reset_n = 1'b0;
        cyc(1'b1, 16'h0);
        cyc(1'b0, 16'h00A0);
        check("reset_dut8", 32'({d8_o, d8_oe, q8_o, q8_oe, done8, err8}), 32'h0);
        check("reset_dut16", 32'({d16_o, d16_oe, q16_o, q16_oe, done16, err16}), 32'h0);
        reset_n = 1'b1;
        cyc(1'b1, 16'h0);

        sel = 1'b0;
        write_txn("wr_basic", 32'h10, 64'h0044_0033_0022_0011, 4);
        read_txn("rd_basic", 32'h10, 3);
        short_cmd("status_wr", 8'h05, 16'h0001);

        header(8'h20, 8'd7, 32'h10);
        e0 = err_cnt;
        for (int k = 0; k < 3; k++) exp_q.push_back({(k % 2 == 0), mdl[key(32'h10 + k)]});
        for (int i = 0; i < DUMMY; i++) cyc(1'b0, 16'h0);
        cyc(1'b0, 16'h0);
        cyc(1'b0, 16'h0);
        cyc(1'b1, 16'h0);
        check("abort_err", 32'({terr, doe, qoe}), 32'h4);
        cyc(1'b1, 16'h0);
        check("abort_err_count", 32'(err_cnt - e0), 32'h1);
        check("abort_drained", 32'(exp_q.size()), 32'h0);
        short_cmd("status_err", 8'h05, 16'h0002);
        short_cmd("status_clr", 8'h05, 16'h0000);

        e0 = err_cnt;
        cyc(1'b0, 16'h0077);
        check("bad_err", 32'({terr, doe, qoe}), 32'h4);
        cyc(1'b0, 16'h00A0);
        cyc(1'b0, 16'h0020);
        check("bad_done_hold", 32'({doe, qoe, tdone, terr}), 32'h0);
        cyc(1'b1, 16'h0);
        check("bad_err_count", 32'(err_cnt - e0), 32'h1);
        read_txn("rd_after_bad", 32'h10, 3);
        short_cmd("read_id", 8'h9F, 16'h005A);

        write_txn("wr_pre", 32'h20, 64'h0055_0099, 2);
        header(8'hA0, 8'd3, 32'h20);
        cyc(1'b0, 16'h0011);
        mdl[key(32'h20)] = 16'h0011;
        e0 = err_cnt;
        reset_n = 1'b0;
        cyc(1'b0, 16'h0022);
        reset_n = 1'b1;
        check("rst_outputs", 32'({d8_o, d8_oe, q8_o, q8_oe, done8, err8}), 32'h0);
        cyc(1'b1, 16'h0);
        check("rst_no_err", 32'(err_cnt - e0), 32'h0);
        read_txn("rd_after_rst", 32'h20, 1);

        header(8'h20, 8'd0, 32'h10);
        e0 = err_cnt;
        reset_n = 1'b0;
        cyc(1'b1, 16'h0);
        reset_n = 1'b1;
        cyc(1'b1, 16'h0);
        check("rst_ncs_no_err", 32'(err_cnt - e0), 32'h0);

        sel = 1'b1;
        write_txn("wr_wrap", 32'hE, 64'h00CC_00BB_00AA, 3);
        read_txn("rd_wrap", 32'hE, 2);
        read_txn("rd_wrap0", 32'h0, 0);
        write_txn("wr_beef", 32'h1234, 64'hBEEF, 1);
        read_txn("rd_beef", 32'h1234, 0);
        short_cmd("read_id16", 8'h9F, 16'h005A);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
